// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions: register-file geometry, write source tags and
// the writeback request payload.
package rv32e_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned NUM_REGS = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    // Which writeback source produced an output-stage entry.
    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_LLU  = 1'b1
    } wb_src_e;

    typedef struct packed {
        reg_addr_t rd;
        xdata_t    data;
        wb_src_e   src;
    } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the rf_write_arbiter handshake and register-file signals.
//   master: writeback sources, issue stage and register file side
//   slave : the arbiter itself
interface rf_write_arbiter_if;
    import rv32e_pkg::*;

    logic      s0_valid;
    reg_addr_t s0_rd;
    xdata_t    s0_data;
    logic      s0_ready;

    logic      s1_valid;
    reg_addr_t s1_rd;
    xdata_t    s1_data;
    logic      s1_ready;

    logic      issue_valid;
    reg_addr_t issue_rd;
    logic      issue_ready;

    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rs1_pending;
    logic      rs2_pending;

    logic      rf_we;
    reg_addr_t rf_rd;
    xdata_t    rf_rd_data;

    modport master (
        output s0_valid, s0_rd, s0_data,
        input  s0_ready,
        output s1_valid, s1_rd, s1_data,
        input  s1_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output rs1, rs2,
        input  rs1_pending, rs2_pending,
        input  rf_we, rf_rd, rf_rd_data
    );

    modport slave (
        input  s0_valid, s0_rd, s0_data,
        output s0_ready,
        input  s1_valid, s1_rd, s1_data,
        output s1_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  rs1, rs2,
        output rs1_pending, rs2_pending,
        output rf_we, rf_rd, rf_rd_data
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency results, one bit per x1..x15.
//   clk, rst_n           : clock, synchronous active-low reset
//   issue_valid/issue_rd : dispatch of a long-latency op; issue_ready low if rd pending
//   clr_en/clr_rd        : long-latency write committing to the register file
//   rs1/rs2              : source lookups; rs1_pending/rs2_pending combinational
module rf_scoreboard
    import rv32e_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    output logic      issue_ready,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_pending,
    output logic      rs2_pending
);

    logic [NUM_REGS-1:1] pend_q;
    logic [NUM_REGS-1:1] pend_d;
    logic [NUM_REGS-1:0] pend_map;
    logic                set_en;

    // x0 is never pending, so it is mapped to a hard zero for lookups.
    assign pend_map    = {pend_q, 1'b0};
    assign issue_ready = !pend_map[issue_rd];
    assign rs1_pending = pend_map[rs1];
    assign rs2_pending = pend_map[rs2];
    assign set_en      = issue_valid && issue_ready;

    // Clear then set, so a same-edge set on the committing register wins.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (clr_en && (clr_rd == REG_AW'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (set_en && (issue_rd == REG_AW'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the in-order
// pipeline (source 0) and the long-latency unit (source 1), with a
// starvation guard for source 1 and a scoreboard of outstanding
// long-latency destinations.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : s0/s1 writeback handshakes, issue handshake, rs1/rs2
//                pending lookups, registered rf_we/rf_rd/rf_rd_data
//   STARVE_MAX : cycles source 1 may wait before a forced grant (1..15)
module rf_write_arbiter
    import rv32e_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_write_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             grant0_c;
    logic             grant1_c;
    wb_req_t          out_q;
    wb_req_t          out_d;
    logic             we_q;
    logic             we_d;
    logic             clr_en_c;

    // Grant, starvation count and output-stage next state.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        starve_d = '0;
        out_d    = out_q;
        we_d     = 1'b0;

        grant1_c = bus.s1_valid && ((starve_q == STARVE_LIM) || !bus.s0_valid);
        grant0_c = bus.s0_valid && !grant1_c;

        if (bus.s1_valid && !grant1_c) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
        end

        // Writes to x0 complete the handshake but never enable the write.
        if (grant0_c) begin
            out_d = '{rd: bus.s0_rd, data: bus.s0_data, src: SRC_PIPE};
            we_d  = (bus.s0_rd != '0);
        end else if (grant1_c) begin
            out_d = '{rd: bus.s1_rd, data: bus.s1_data, src: SRC_LLU};
            we_d  = (bus.s1_rd != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            out_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            out_q    <= out_d;
            we_q     <= we_d;
        end
    end

    assign bus.s0_ready   = grant0_c;
    assign bus.s1_ready   = grant1_c;
    assign bus.rf_we      = we_q;
    assign bus.rf_rd      = out_q.rd;
    assign bus.rf_rd_data = out_q.data;

    // A long-latency result clears its pending bit on the commit edge.
    assign clr_en_c = we_q && (out_q.src == SRC_LLU);

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .clr_en      (clr_en_c),
        .clr_rd      (out_q.rd),
        .rs1         (bus.rs1),
        .rs2         (bus.rs2),
        .rs1_pending (bus.rs1_pending),
        .rs2_pending (bus.rs2_pending)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: constant vector table, directed
// corner sequences, then random traffic against a reference model.
module tb_rf_write_arbiter;

    localparam int unsigned SM = 4;

    logic clk;
    logic rst_n;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_we;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    bit          m_tag;
    int          m_wait;
    bit          m_pend[16];

    typedef struct {
        bit s0v;
        bit s1v;
        bit exp_s0r;
        bit exp_s1r;
        bit exp_we;
    } vec_t;

    vec_t tbl[15];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_tag  = 1'b0;
        m_wait = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endfunction

    // Grant decision from the priority rules and the wait count.
    function automatic void model_comb(output bit g0, output bit g1, output bit ir);
        g1 = bus.s1_valid && ((m_wait >= int'(SM)) || !bus.s0_valid);
        g0 = bus.s0_valid && !g1;
        ir = !((bus.issue_rd != 0) && m_pend[bus.issue_rd]);
    endfunction

    function automatic bit model_pend(logic [3:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    task automatic set_idle();
        bus.s0_valid    = 1'b0;
        bus.s0_rd       = '0;
        bus.s0_data     = '0;
        bus.s1_valid    = 1'b0;
        bus.s1_rd       = '0;
        bus.s1_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
    endtask

    // Compare every output against the model mid-cycle.
    task automatic sample();
        bit g0, g1, ir;
        @(negedge clk);
        model_comb(g0, g1, ir);
        if (rst_n) begin
            chk("s0_ready", 32'(bus.s0_ready), 32'(g0));
            chk("s1_ready", 32'(bus.s1_ready), 32'(g1));
            chk("issue_ready", 32'(bus.issue_ready), 32'(ir));
            chk("rs1_pending", 32'(bus.rs1_pending), 32'(model_pend(bus.rs1)));
            chk("rs2_pending", 32'(bus.rs2_pending), 32'(model_pend(bus.rs2)));
        end
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
        chk("rf_rd_data", bus.rf_rd_data, m_data);
    endtask

    // Advance one edge and update the model from the inputs seen at it.
    task automatic tick();
        bit g0, g1, ir;
        bit rst_l, s1v, iv;
        logic [3:0] s0rd, s1rd, ird;
        logic [31:0] s0d, s1d;
        model_comb(g0, g1, ir);
        rst_l = rst_n;
        s1v   = bus.s1_valid;
        iv    = bus.issue_valid;
        s0rd  = bus.s0_rd;
        s1rd  = bus.s1_rd;
        ird   = bus.issue_rd;
        s0d   = bus.s0_data;
        s1d   = bus.s1_data;
        @(posedge clk);
        if (!rst_l) begin
            model_reset();
        end else begin
            if (m_we && m_tag) m_pend[m_rd] = 1'b0;
            if (iv && ir && (ird != 0)) m_pend[ird] = 1'b1;
            if (g0) begin
                m_we = (s0rd != 0); m_rd = s0rd; m_data = s0d; m_tag = 1'b0;
            end else if (g1) begin
                m_we = (s1rd != 0); m_rd = s1rd; m_data = s1d; m_tag = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (s1v && !g1) m_wait = (m_wait + 1 > int'(SM)) ? int'(SM) : m_wait + 1;
            else            m_wait = 0;
        end
        #1;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 1};
        tbl[3]  = '{1, 1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 0, 1};
        tbl[6]  = '{1, 1, 1, 0, 1};
        tbl[7]  = '{1, 1, 0, 1, 1};
        tbl[8]  = '{1, 1, 1, 0, 1};
        tbl[9]  = '{1, 1, 1, 0, 1};
        tbl[10] = '{1, 1, 1, 0, 1};
        tbl[11] = '{1, 1, 1, 0, 1};
        tbl[12] = '{1, 1, 0, 1, 1};
        tbl[13] = '{0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 0};

        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state and idle.
        sample();
        chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset_issue_ready", 32'(bus.issue_ready), 32'd1);
        tick();

        // Vector table: readies follow valids, starvation rotation.
        for (int i = 0; i < 15; i++) begin
            bus.s0_valid = tbl[i].s0v;
            bus.s0_rd    = 4'd1;
            bus.s0_data  = $urandom;
            bus.s1_valid = tbl[i].s1v;
            bus.s1_rd    = 4'd2;
            bus.s1_data  = $urandom;
            sample();
            chk($sformatf("tbl%0d_s0_ready", i), 32'(bus.s0_ready), 32'(tbl[i].exp_s0r));
            chk($sformatf("tbl%0d_s1_ready", i), 32'(bus.s1_ready), 32'(tbl[i].exp_s1r));
            chk($sformatf("tbl%0d_rf_we", i), 32'(bus.rf_we), 32'(tbl[i].exp_we));
            tick();
        end

        // Issue to x5, re-issue blocked, long-latency write clears it.
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 4'd5;
        sample();
        chk("issue5_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        bus.rs1 = 4'd5;
        sample();
        chk("reissue5_ready", 32'(bus.issue_ready), 32'd0);
        chk("rs1_pending5", 32'(bus.rs1_pending), 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        bus.s1_valid    = 1'b1;
        bus.s1_rd       = 4'd5;
        bus.s1_data     = 32'hDEADBEEF;
        sample();
        chk("s1_ready_wr5", 32'(bus.s1_ready), 32'd1);
        tick();
        bus.s1_valid = 1'b0;
        sample();
        chk("wr5_rf_we", 32'(bus.rf_we), 32'd1);
        chk("wr5_rf_rd", 32'(bus.rf_rd), 32'd5);
        chk("wr5_rf_data", bus.rf_rd_data, 32'hDEADBEEF);
        chk("wr5_still_pending", 32'(bus.rs1_pending), 32'd1);
        tick();
        sample();
        chk("wr5_cleared", 32'(bus.rs1_pending), 32'd0);
        tick();

        // Write to x0 is accepted but dropped.
        set_idle();
        bus.s0_valid = 1'b1;
        bus.s0_rd    = 4'd0;
        bus.s0_data  = 32'h1234;
        sample();
        chk("x0_s0_ready", 32'(bus.s0_ready), 32'd1);
        tick();
        set_idle();
        sample();
        chk("x0_rf_we", 32'(bus.rf_we), 32'd0);
        tick();

        // Set and clear of x7 on the same edge: set wins.
        bus.s1_valid = 1'b1;
        bus.s1_rd    = 4'd7;
        bus.s1_data  = 32'h0000_7777;
        sample();
        tick();
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 4'd7;
        sample();
        chk("same_edge_rf_we", 32'(bus.rf_we), 32'd1);
        chk("same_edge_rf_rd", 32'(bus.rf_rd), 32'd7);
        chk("same_edge_issue_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        set_idle();
        bus.rs2 = 4'd7;
        sample();
        chk("same_edge_pending7", 32'(bus.rs2_pending), 32'd1);
        tick();

        // Reset mid-operation.
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 4'd3;
        bus.s0_valid    = 1'b1;
        bus.s0_rd       = 4'd4;
        bus.s0_data     = 32'hCAFE_0004;
        bus.rs1         = 4'd3;
        sample();
        tick();
        bus.issue_valid = 1'b0;
        bus.s1_valid    = 1'b1;
        bus.s1_rd       = 4'd9;
        rst_n           = 1'b0;
        sample();
        chk("prerst_rf_we", 32'(bus.rf_we), 32'd1);
        chk("prerst_pending3", 32'(bus.rs1_pending), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i == 0) begin
                chk("postrst_rf_we", 32'(bus.rf_we), 32'd0);
                chk("postrst_pending3", 32'(bus.rs1_pending), 32'd0);
            end
            chk($sformatf("postrst_s1_ready%0d", i), 32'(bus.s1_ready), 32'(i == 4));
            tick();
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.s0_valid    = ($urandom_range(0, 3) != 0);
            bus.s0_rd       = 4'($urandom_range(0, 15));
            bus.s0_data     = $urandom;
            bus.s1_valid    = ($urandom_range(0, 2) != 0);
            bus.s1_rd       = 4'($urandom_range(0, 15));
            bus.s1_data     = $urandom;
            bus.issue_valid = ($urandom_range(0, 1) != 0);
            bus.issue_rd    = 4'($urandom_range(0, 15));
            bus.rs1         = 4'($urandom_range(0, 15));
            bus.rs2         = 4'($urandom_range(0, 15));
            rst_n           = ($urandom_range(0, 60) != 0);
            sample();
            tick();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
